keypad_scan_ctrl: RTL and testbench

Parametrised matrix-keypad scanner. It derives an exact-rate scan tick from the system clock, walks an active-low column strobe across the matrix, and samples the rows once per column. Each full-matrix frame is debounced, and the block reports single clean key presses to the clock/alarm-setting logic as a one-cycle `key_valid` pulse with a key code. It replaces the free-running power-of-two scan clock with a divider-exact tick and adds scanning, debouncing and multi-key rejection, all in the system clock domain.

---
 rtl/keypad_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: exact-rate column strobe, frame debounce and single-key
// reporting with multi-key rejection, all on clk.
//
// state     | meaning
// S_IDLE    | stable state has no key pressed
// S_PRESSED | stable state has exactly one key; key_code holds it
// S_MULTI   | two or more keys seen; held until everything is released
module keypad_scan_ctrl #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int SCAN_HZ  = 1000,
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int DEBOUNCE = 4,
   localparam int KW      = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] row_in,
   output logic [COLS-1:0] col_out,
   output logic            scan_tick,
   output logic            key_valid,
   output logic [KW-1:0]   key_code,
   output logic            key_held,
   output logic            multi_key
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int NK  = ROWS * COLS;
   localparam int DW  = $clog2(DIV);
   localparam int CW  = $clog2(COLS);
   localparam int BW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_MULTI} state_t;

   state_t          state;
   logic [DW-1:0]   div_cnt;
   logic [CW-1:0]   col_idx;
   logic [CW-1:0]   col_nxt;
   logic [NK-1:0]   frame_buf;
   logic [NK-1:0]   frame_next;
   logic [NK-1:0]   prev_snap;
   logic [NK-1:0]   stable;
   logic [BW-1:0]   deb_cnt;
   logic [BW-1:0]   deb_next;
   logic            frame_end;
   logic            accept;
   logic [1:0]      n_keys;
   logic [KW-1:0]   low_idx;

   assign scan_tick = (div_cnt == DW'(DIV - 1));
   assign frame_end = scan_tick && (col_idx == CW'(COLS - 1));
   assign col_nxt   = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);

   // Current column's rows merged into the frame; on frame end this is the snapshot.
   always_comb begin
      frame_next = frame_buf;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (col_idx == CW'(c)) frame_next[r*COLS + c] = ~row_in[r];
         end
      end
   end

   always_comb begin
      deb_next = '0;
      if (frame_next == prev_snap) begin
         deb_next = (deb_cnt == BW'(DEBOUNCE - 1)) ? deb_cnt : deb_cnt + BW'(1);
      end
   end

   assign accept = frame_end && (deb_next == BW'(DEBOUNCE - 1));

   // Key count saturates at 2; scanning downward leaves the lowest index.
   always_comb begin
      n_keys  = 2'd0;
      low_idx = '0;
      for (int i = NK - 1; i >= 0; i--) begin
         if (frame_next[i]) begin
            low_idx = KW'(i);
            if (n_keys != 2'd2) n_keys = n_keys + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         div_cnt   <= '0;
         col_idx   <= '0;
         col_out   <= ~COLS'(1);
         frame_buf <= '0;
         prev_snap <= '0;
         stable    <= '0;
         deb_cnt   <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
         key_held  <= 1'b0;
         multi_key <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         div_cnt   <= scan_tick ? '0 : div_cnt + DW'(1);
         if (scan_tick) begin
            frame_buf <= frame_next;
            col_idx   <= col_nxt;
            col_out   <= ~(COLS'(1) << col_nxt);
         end
         if (frame_end) begin
            prev_snap <= frame_next;
            deb_cnt   <= deb_next;
         end
         if (accept) begin
            stable <= frame_next;
            case (state)
               S_IDLE: begin
                  if (n_keys == 2'd1) begin
                     state     <= S_PRESSED;
                     key_valid <= 1'b1;
                     key_code  <= low_idx;
                     key_held  <= 1'b1;
                  end else if (n_keys == 2'd2) begin
                     state     <= S_MULTI;
                     multi_key <= 1'b1;
                  end
               end
               S_PRESSED: begin
                  if (n_keys == 2'd0) begin
                     state    <= S_IDLE;
                     key_held <= 1'b0;
                  end else if (n_keys == 2'd2) begin
                     state     <= S_MULTI;
                     key_held  <= 1'b0;
                     multi_key <= 1'b1;
                  end else if (low_idx != key_code) begin
                     key_valid <= 1'b1;
                     key_code  <= low_idx;
                  end
               end
               S_MULTI: begin
                  if (n_keys == 2'd0) begin
                     state     <= S_IDLE;
                     multi_key <= 1'b0;
                  end
               end
               default: begin
                  state     <= S_IDLE;
                  key_held  <= 1'b0;
                  multi_key <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix emulation, frame-level reference model
// checked every cycle, plus directed scenarios with hand-computed timing.
module tb_keypad_scan_ctrl;

   localparam int DIV      = 10;
   localparam int ROWS     = 4;
   localparam int COLS     = 4;
   localparam int DEBOUNCE = 3;
   localparam int NK       = ROWS * COLS;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [ROWS-1:0] row_in;
   logic [COLS-1:0] col_out;
   logic            scan_tick;
   logic            key_valid;
   logic [3:0]      key_code;
   logic            key_held;
   logic            multi_key;
   logic [NK-1:0]   keys = '0;

   int n_cmp = 0;
   int n_bad = 0;

   keypad_scan_ctrl #(
      .CLK_HZ(1000), .SCAN_HZ(100), .ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEBOUNCE)
   ) dut (
      .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .scan_tick(scan_tick),
      .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .multi_key(multi_key)
   );

   always #5 clk = ~clk;

   // A row reads low when any pressed key on it sits in a driven (low) column.
   always_comb begin
      for (int r = 0; r < ROWS; r++) row_in[r] = ~|(keys[r*COLS +: COLS] & ~col_out);
   end

   // Reference model: t = cycles since reset release, frames as whole snapshots,
   // run = length of the current run of identical snapshots (reset counts as one).
   bit            m_on = 0;
   int            m_t, m_run;
   logic [NK-1:0] m_frame, m_last;
   bit            m_valid, m_held, m_multi;
   logic [3:0]    m_code;

   always @(posedge clk) begin
      if (rst) begin
         m_on = 1; m_t = 0; m_run = 1; m_frame = '0; m_last = '0;
         m_valid = 0; m_held = 0; m_multi = 0; m_code = '0;
      end else if (m_on) begin
         m_valid = 0;
         if (m_t % DIV == DIV - 1) begin
            int col;
            col = (m_t / DIV) % COLS;
            for (int r = 0; r < ROWS; r++) m_frame[r*COLS + col] = ~row_in[r];
            if (col == COLS - 1) begin
               if (m_frame == m_last) m_run++; else m_run = 1;
               m_last = m_frame;
               if (m_run >= DEBOUNCE) begin
                  int n, low;
                  n = $countones(m_frame);
                  low = 0;
                  for (int i = NK - 1; i >= 0; i--) if (m_frame[i]) low = i;
                  if (n == 0) begin
                     m_held = 0; m_multi = 0;
                  end else if (m_multi) begin
                     m_multi = 1;
                  end else if (n >= 2) begin
                     m_multi = 1; m_held = 0;
                  end else begin
                     if (!m_held || low != int'(m_code)) begin
                        m_valid = 1; m_code = 4'(low);
                     end
                     m_held = 1;
                  end
               end
            end
         end
         m_t++;
      end
   end

   int         v_cnt = 0;
   int         tick_cnt = 0;
   logic [3:0] one4 = 4'b0001;

   always @(negedge clk) begin
      if (m_on) begin
         logic [11:0] act, exp;
         logic [3:0]  exp_col;
         exp_col = ~(one4 << ((m_t / DIV) % COLS));
         exp = {(m_t % DIV == DIV - 1), exp_col, m_valid, m_code, m_held, m_multi};
         act = {scan_tick, col_out, key_valid, key_code, key_held, multi_key};
         n_cmp++;
         if (act !== exp) begin
            n_bad++;
            $display("FAIL outputs t=%0d: got %b required %b (tick,col,valid,code,held,multi)",
                     m_t, act, exp);
         end
         if (key_valid === 1'b1) v_cnt++;
         if (scan_tick === 1'b1) tick_cnt++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at t=%0d: got %0d required %0d", name, m_t, act, exp);
      end
   endtask

   task automatic wait_t(input int target);
      while (m_t < target) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      keys = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      v_cnt = 0;
      tick_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Divider and column walk, no keys
      do_reset();
      chk("col_t0", int'(col_out), 4'b1110);
      wait_t(9);  chk("tick_t9", int'(scan_tick), 1);
      wait_t(10); chk("col_t10", int'(col_out), 4'b1101); chk("tick_t10", int'(scan_tick), 0);
      wait_t(20); chk("col_t20", int'(col_out), 4'b1011);
      wait_t(30); chk("col_t30", int'(col_out), 4'b0111);
      wait_t(40); chk("col_t40", int'(col_out), 4'b1110);
      wait_t(80); chk("tick_count", tick_cnt, 8); chk("idle_pulses", v_cnt, 0);

      // Single press of key 6, then release
      do_reset();
      keys = NK'(1) << 6;
      wait_t(119); chk("s_valid_early", int'(key_valid), 0);
      wait_t(120); chk("s_valid", int'(key_valid), 1); chk("s_code", int'(key_code), 6);
      chk("s_held", int'(key_held), 1);
      wait_t(121); chk("s_valid_one_cycle", int'(key_valid), 0);
      wait_t(160); keys = '0;
      wait_t(279); chk("s_held_before_rel", int'(key_held), 1);
      wait_t(280); chk("s_held_rel", int'(key_held), 0);
      wait_t(320); chk("s_pulses", v_cnt, 1);

      // Bouncing key 9: toggles each frame for four frames, then held
      do_reset();
      keys = NK'(1) << 9;
      wait_t(40);  keys = '0;
      wait_t(80);  keys = NK'(1) << 9;
      wait_t(120); keys = '0;
      wait_t(160); keys = NK'(1) << 9;
      wait_t(279); chk("b_no_early", v_cnt, 0);
      wait_t(280); chk("b_valid", int'(key_valid), 1); chk("b_code", int'(key_code), 9);
      wait_t(320); chk("b_pulses", v_cnt, 1);

      // Multi-key: 0 and 5, then only 0, then none, then key 3
      do_reset();
      keys = (NK'(1) << 0) | (NK'(1) << 5);
      wait_t(119); chk("m_multi_early", int'(multi_key), 0);
      wait_t(120); chk("m_multi", int'(multi_key), 1);
      wait_t(160); keys = NK'(1) << 0;
      wait_t(300); chk("m_multi_one_left", int'(multi_key), 1); chk("m_no_pulse", v_cnt, 0);
      wait_t(320); keys = '0;
      wait_t(439); chk("m_multi_before_idle", int'(multi_key), 1);
      wait_t(440); chk("m_multi_idle", int'(multi_key), 0);
      keys = NK'(1) << 3;
      wait_t(560); chk("m_valid3", int'(key_valid), 1); chk("m_code3", int'(key_code), 3);
      wait_t(600); chk("m_pulses", v_cnt, 1);

      // Direct switch from key 2 to key 14
      do_reset();
      keys = NK'(1) << 2;
      wait_t(120); chk("d_valid2", int'(key_valid), 1); chk("d_code2", int'(key_code), 2);
      wait_t(160); keys = NK'(1) << 14;
      wait_t(240); chk("d_held_mid", int'(key_held), 1); chk("d_code_mid", int'(key_code), 2);
      wait_t(280); chk("d_valid14", int'(key_valid), 1); chk("d_code14", int'(key_code), 14);
      chk("d_held14", int'(key_held), 1);
      wait_t(320); chk("d_pulses", v_cnt, 2);

      // Reset pulse while key 7 is held
      do_reset();
      keys = NK'(1) << 7;
      wait_t(120); chk("r_valid_pre", int'(key_valid), 1); chk("r_code_pre", int'(key_code), 7);
      wait_t(150);
      rst = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      v_cnt = 0;
      chk("r_col", int'(col_out), 4'b1110);
      chk("r_held", int'(key_held), 0);
      chk("r_code", int'(key_code), 0);
      chk("r_valid", int'(key_valid), 0);
      chk("r_multi", int'(multi_key), 0);
      chk("r_tick", int'(scan_tick), 0);
      wait_t(119); chk("r_valid_early", int'(key_valid), 0);
      wait_t(120); chk("r_valid_post", int'(key_valid), 1); chk("r_code_post", int'(key_code), 7);
      wait_t(160); chk("r_pulses", v_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
